// File: rtl/cpu_ctrl_pkg.sv
// Shared parameters for the cpu_ctrl slice: datapath widths, instruction
// field offsets, the halt opcode and the controller state encoding.
package cpu_ctrl_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int BUS_WIDTH    = 8;
    localparam int OPCODE_WIDTH = 6;
    localparam int INSTR_WIDTH  = 32;

    // Instruction layout: [31:26] opcode, [25:24] reserved,
    // [23:16] dst, [15:8] src1, [7:0] src2
    localparam int OPC_LSB  = 26;
    localparam int RSV_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = '1;

    typedef enum logic [2:0] {
        SIDLE  = 3'd0,
        SFETCH = 3'd1,
        SREAD  = 3'd2,
        SCALC  = 3'd3,
        SWRITE = 3'd4,
        SHALT  = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Bus bundle between the cpu_ctrl sequencer and its environment
// (instruction memory, register file, ALU, status).
//   master : cpu_ctrl side (drives fetch request, rf/alu controls, status)
//   slave  : environment side (drives run, fetch data/ack, rf read data,
//            alu result/status)
interface cpu_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = cpu_ctrl_pkg::DATA_WIDTH,
    parameter int BUS_WIDTH    = cpu_ctrl_pkg::BUS_WIDTH,
    parameter int OPCODE_WIDTH = cpu_ctrl_pkg::OPCODE_WIDTH,
    parameter int INSTR_WIDTH  = cpu_ctrl_pkg::INSTR_WIDTH
);
    logic                    run;
    logic                    imem_req;
    logic [BUS_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0]  imem_rdata;
    logic                    imem_ack;
    logic [BUS_WIDTH-1:0]    rf_raddr1;
    logic [BUS_WIDTH-1:0]    rf_raddr2;
    logic [DATA_WIDTH-1:0]   rf_rdata1;
    logic [DATA_WIDTH-1:0]   rf_rdata2;
    logic                    alu_en;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [DATA_WIDTH-1:0]   alu_value1;
    logic [DATA_WIDTH-1:0]   alu_value2;
    logic [BUS_WIDTH-1:0]    alu_addr1;
    logic [BUS_WIDTH-1:0]    alu_addr2;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_calc_done;
    logic                    alu_err;
    logic                    alu_finish;
    logic                    rf_we;
    logic [BUS_WIDTH-1:0]    rf_waddr;
    logic [DATA_WIDTH-1:0]   rf_wdata;
    logic                    halted;
    logic                    fault;
    logic [2:0]              state;
    logic [15:0]             retired;

    modport master (
        input  run, imem_rdata, imem_ack, rf_rdata1, rf_rdata2,
               alu_result, alu_calc_done, alu_err, alu_finish,
        output imem_req, imem_addr, rf_raddr1, rf_raddr2, alu_en, alu_opcode,
               alu_value1, alu_value2, alu_addr1, alu_addr2, rf_we, rf_waddr,
               rf_wdata, halted, fault, state, retired
    );

    modport slave (
        output run, imem_rdata, imem_ack, rf_rdata1, rf_rdata2,
               alu_result, alu_calc_done, alu_err, alu_finish,
        input  imem_req, imem_addr, rf_raddr1, rf_raddr2, alu_en, alu_opcode,
               alu_value1, alu_value2, alu_addr1, alu_addr2, rf_we, rf_waddr,
               rf_wdata, halted, fault, state, retired
    );

endinterface

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction sequencer for an external ALU and register file.
// Fetches one instruction per pass, reads its operands, runs the ALU and
// writes the result back; stops on the halt opcode or an ALU error.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bus  : cpu_ctrl_if.master (fetch, rf read/write, alu control, status)
//
// state  | meaning
// -------+---------------------------------------------------
// SIDLE  | wait for run
// SFETCH | imem_req high at pc until imem_ack; latch IR, pc+1
// SREAD  | latch rf read data as ALU operands; halt opcode check
// SCALC  | alu_en high until calc_done (or alu_err -> fault)
// SWRITE | one-cycle rf write of alu_result, bump retired
// SHALT  | terminal until reset
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = cpu_ctrl_pkg::DATA_WIDTH,
    parameter int BUS_WIDTH    = cpu_ctrl_pkg::BUS_WIDTH,
    parameter int OPCODE_WIDTH = cpu_ctrl_pkg::OPCODE_WIDTH,
    parameter int INSTR_WIDTH  = cpu_ctrl_pkg::INSTR_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    cpu_ctrl_if.master  bus
);

    state_t                  r_state;
    state_t                  w_next;
    logic [BUS_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0]  r_ir;
    logic [DATA_WIDTH-1:0]   r_val1;
    logic [DATA_WIDTH-1:0]   r_val2;
    logic [15:0]             r_retired;
    logic                    r_fault;
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic                    w_unused;

    assign w_opcode = r_ir[OPC_LSB +: OPCODE_WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            SIDLE:   if (bus.run) w_next = SFETCH;
            SFETCH:  if (bus.imem_ack) w_next = SREAD;
            SREAD:   w_next = (w_opcode == OPC_HALT) ? SHALT : SCALC;
            SCALC: begin
                // error takes priority over a simultaneous calc_done
                if (bus.alu_err)            w_next = SHALT;
                else if (bus.alu_calc_done) w_next = SWRITE;
            end
            SWRITE:  w_next = SFETCH;
            SHALT:   w_next = SHALT;
            default: w_next = SHALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SIDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_val1    <= '0;
            r_val2    <= '0;
            r_retired <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == SFETCH && bus.imem_ack) begin
                r_ir <= bus.imem_rdata;
                r_pc <= r_pc + BUS_WIDTH'(1);
            end
            if (r_state == SREAD) begin
                r_val1 <= bus.rf_rdata1;
                r_val2 <= bus.rf_rdata2;
            end
            if (r_state == SCALC && bus.alu_err) begin
                r_fault <= 1'b1;
            end
            if (r_state == SWRITE && r_retired != 16'hFFFF) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign bus.imem_req   = (r_state == SFETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.rf_raddr1  = r_ir[SRC1_LSB +: BUS_WIDTH];
    assign bus.rf_raddr2  = r_ir[SRC2_LSB +: BUS_WIDTH];
    assign bus.alu_en     = (r_state == SCALC);
    assign bus.alu_opcode = w_opcode;
    assign bus.alu_value1 = r_val1;
    assign bus.alu_value2 = r_val2;
    assign bus.alu_addr1  = r_ir[SRC1_LSB +: BUS_WIDTH];
    assign bus.alu_addr2  = r_ir[SRC2_LSB +: BUS_WIDTH];
    assign bus.rf_we      = (r_state == SWRITE);
    assign bus.rf_waddr   = r_ir[DST_LSB +: BUS_WIDTH];
    // write data gated so the bus reads zero whenever no write is strobed
    assign bus.rf_wdata   = (r_state == SWRITE) ? bus.alu_result : '0;
    assign bus.halted     = (r_state == SHALT);
    assign bus.fault      = r_fault;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;

    // alu_finish and the reserved IR bits carry no meaning for sequencing
    assign w_unused = ^{bus.alu_finish, r_ir[RSV_LSB +: 2]};

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

    logic clk;
    logic rst;

    cpu_ctrl_if bus ();

    cpu_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    localparam logic [31:0] I_ADD12 = 32'h0003_0102;  // r3 = r1 + r2
    localparam logic [31:0] I_SUB   = 32'h0404_0302;  // r4 = r3 - r2
    localparam logic [31:0] I_XOR   = 32'h0805_0403;  // r5 = r4 ^ r3
    localparam logic [31:0] I_NOP   = 32'h0800_0000;  // r0 = r0 ^ r0
    localparam logic [31:0] I_HALT  = 32'hFC00_0000;

    int          checks;
    int          errors;
    int          ack_delay;
    int          calc_delay;
    logic        err_inject;
    int          wcnt;
    int          we_count;
    logic [7:0]  last_wdata;
    logic [31:0] mem [256];
    logic [7:0]  mdl [256];
    logic [7:0]  rf  [256];
    wr_t         sb [$];
    logic [7:0]  fetch_log [$];
    logic [7:0]  alu_result_r;
    int          calc_cnt;

    function automatic logic [7:0] rf_init(input int i);
        if (i == 1) return 8'd5;
        if (i == 2) return 8'd7;
        return 8'(i);
    endfunction

    function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // register file and ALU behavioural models
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) rf[i] <= rf_init(i);
        end else if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_r <= '0;
            calc_cnt     <= 0;
        end else begin
            calc_cnt <= bus.alu_en ? calc_cnt + 1 : 0;
            if (bus.alu_en && bus.alu_calc_done && !bus.alu_err)
                alu_result_r <= alu_f(bus.alu_opcode, bus.alu_value1, bus.alu_value2);
        end
    end

    assign bus.rf_rdata1     = rf[bus.rf_raddr1];
    assign bus.rf_rdata2     = rf[bus.rf_raddr2];
    assign bus.alu_result    = alu_result_r;
    assign bus.alu_calc_done = bus.alu_en && (calc_cnt >= calc_delay);
    assign bus.alu_err       = bus.alu_en && err_inject;
    assign bus.alu_finish    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: observe write-back at the negedge, then act as instruction memory.
    task automatic cycle();
        wr_t         e;
        logic [31:0] ins;
        logic [7:0]  res;
        @(negedge clk);
        if (bus.rf_we) begin
            we_count++;
            last_wdata = bus.rf_wdata;
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_waddr", 32'(bus.rf_waddr), 32'(e.addr));
                chk("sb_wdata", 32'(bus.rf_wdata), 32'(e.data));
            end
        end
        if (bus.imem_req && wcnt >= ack_delay) begin
            ins = mem[bus.imem_addr];
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = ins;
            wcnt = 0;
            fetch_log.push_back(bus.imem_addr);
            if (ins[31:26] != 6'h3F && !err_inject) begin
                res = alu_f(ins[31:26], mdl[ins[15:8]], mdl[ins[7:0]]);
                mdl[ins[23:16]] = res;
                sb.push_back('{addr: ins[23:16], data: res});
            end
        end else begin
            bus.imem_ack = 1'b0;
            wcnt = bus.imem_req ? wcnt + 1 : 0;
        end
    endtask

    task automatic clear_bench();
        bus.run      = 1'b0;
        bus.imem_ack = 1'b0;
        wcnt         = 0;
        we_count     = 0;
        last_wdata   = '0;
        sb.delete();
        fetch_log.delete();
        for (int i = 0; i < 256; i++) mdl[i] = rf_init(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_bench();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run();
        bus.run = 1'b1;
        cycle();
        bus.run = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.halted && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(bus.halted), 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (bus.state !== st && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(bus.state), 32'(st));
    endtask

    initial begin
        int lat;
        int reqc;
        checks     = 0;
        errors     = 0;
        ack_delay  = 0;
        calc_delay = 0;
        err_inject = 1'b0;
        rst        = 1'b0;
        bus.imem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = I_HALT;
        clear_bench();
        do_reset();

        // reset state
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        // idle holds without run
        repeat (3) cycle();
        chk("idle_hold", 32'(bus.state), 32'd0);

        // ADD with immediate ack: write exactly 4 cycles after run
        mem[0] = I_ADD12;
        mem[1] = I_HALT;
        bus.run = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            cycle();
            bus.run = 1'b0;
            if (bus.rf_we) begin
                lat = n;
                break;
            end
        end
        chk("add_latency", 32'(lat), 32'd4);
        chk("add_waddr", 32'(bus.rf_waddr), 32'd3);
        chk("add_wdata", 32'(bus.rf_wdata), 32'd12);
        run_to_halt("add_halt", 20);
        chk("add_retired", 32'(bus.retired), 32'd1);
        chk("add_pc", 32'(bus.imem_addr), 32'd2);
        chk("add_fault", 32'(bus.fault), 32'd0);

        // halt opcode: SREAD then SHALT, no write
        do_reset();
        mem[0] = I_HALT;
        start_run();
        wait_state("halt_read", 3'd2, 10);
        cycle();
        chk("halt_state", 32'(bus.state), 32'd5);
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_pc", 32'(bus.imem_addr), 32'd1);
        bus.run = 1'b1;
        repeat (3) cycle();
        bus.run = 1'b0;
        chk("halt_hold", 32'(bus.state), 32'd5);
        chk("halt_no_we", 32'(we_count), 32'd0);

        // fetch stall: ack after 3 wait cycles
        do_reset();
        ack_delay = 3;
        mem[0] = I_ADD12;
        mem[1] = I_HALT;
        start_run();
        reqc = 0;
        for (int n = 0; n < 20 && bus.state !== 3'd2; n++) begin
            if (bus.imem_req) begin
                reqc++;
                chk("stall_addr", 32'(bus.imem_addr), 32'd0);
            end
            cycle();
        end
        chk("stall_req_cycles", 32'(reqc), 32'd4);
        run_to_halt("stall_halt", 40);
        chk("stall_retired", 32'(bus.retired), 32'd1);
        chk("stall_wdata", 32'(last_wdata), 32'd12);
        ack_delay = 0;

        // three-instruction program with slow ALU
        do_reset();
        calc_delay = 2;
        mem[0] = I_ADD12;
        mem[1] = I_SUB;
        mem[2] = I_XOR;
        mem[3] = I_HALT;
        start_run();
        run_to_halt("prog_halt", 60);
        chk("prog_retired", 32'(bus.retired), 32'd3);
        chk("prog_last_wdata", 32'(last_wdata), 32'd9);
        chk("prog_sb_empty", 32'(sb.size()), 32'd0);
        calc_delay = 0;

        // ALU error: fault halt, no write
        do_reset();
        err_inject = 1'b1;
        mem[0] = I_ADD12;
        start_run();
        run_to_halt("fault_halt", 20);
        chk("fault_flag", 32'(bus.fault), 32'd1);
        chk("fault_no_we", 32'(we_count), 32'd0);
        chk("fault_retired", 32'(bus.retired), 32'd0);
        err_inject = 1'b0;

        // pc wrap after 256 NOPs
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = I_NOP;
        start_run();
        for (int n = 0; n < 1200 && fetch_log.size() < 257; n++) cycle();
        chk("wrap_fetches", 32'(fetch_log.size()), 32'd257);
        if (fetch_log.size() >= 257) begin
            chk("wrap_addr255", 32'(fetch_log[255]), 32'd255);
            chk("wrap_addr0", 32'(fetch_log[256]), 32'd0);
        end
        chk("wrap_retired", 32'(bus.retired), 32'd256);
        for (int i = 0; i < 256; i++) mem[i] = I_HALT;

        // reset asserted while in SCALC of the second instruction
        do_reset();
        mem[0] = I_ADD12;
        mem[1] = I_ADD12;
        mem[2] = I_HALT;
        start_run();
        for (int n = 0; n < 30 && !(bus.retired == 16'd1 && bus.state == 3'd3); n++) cycle();
        chk("mid_in_calc", 32'(bus.state), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_state", 32'(bus.state), 32'd0);
        chk("mid_alu_en", 32'(bus.alu_en), 32'd0);
        chk("mid_addr", 32'(bus.imem_addr), 32'd0);
        chk("mid_val1", 32'(bus.alu_value1), 32'd0);
        chk("mid_retired", 32'(bus.retired), 32'd0);
        chk("mid_strobes", 32'({bus.imem_req, bus.rf_we, bus.halted, bus.fault}), 32'd0);
        clear_bench();
        @(negedge clk);
        rst = 1'b0;
        start_run();
        for (int n = 0; n < 10 && fetch_log.size() == 0; n++) cycle();
        chk("mid_fetches", 32'(fetch_log.size() > 0), 32'd1);
        if (fetch_log.size() > 0) chk("mid_first_addr", 32'(fetch_log[0]), 32'd0);
        run_to_halt("mid_halt", 40);
        chk("mid_retired_after", 32'(bus.retired), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameters DATA_WIDTH, default 8, the datapath word width.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, the register/instruction address width.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 6, the ALU opcode width.
REQ-004 SHALL have parameter INSTR_WIDTH, default 32: [31:26] opcode, [25:24] reserved, [23:16] dst, [15:8] src1, [7:0] src2.
REQ-005 SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  async reset, active high.
REQ-006 Ports, in order after clk and rst:
- run  in  1  start execution from SIDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  BUS_WIDTH  program counter.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- imem_ack  in  1  instruction valid.
- rf_raddr1, rf_raddr2  out  BUS_WIDTH  register read addresses.
- rf_rdata1, rf_rdata2  in  DATA_WIDTH  combinational read data.
- alu_en  out  1  ALU result-register enable.
- alu_opcode  out  OPCODE_WIDTH  ALU operation.
- alu_value1, alu_value2  out  DATA_WIDTH  latched operands.
- alu_addr1, alu_addr2  out  BUS_WIDTH  immediate operands (src fields).
- alu_result  in  DATA_WIDTH  registered ALU result.
- alu_calc_done, alu_err, alu_finish  in  1  ALU status.
- rf_we  out  1  register write strobe.
- rf_waddr  out  BUS_WIDTH  write address.
- rf_wdata  out  DATA_WIDTH  write data.
- halted  out  1  SHALT reached.
- fault  out  1  halted due to alu_err.
- state  out  3  current state encoding.
- retired  out  16  instructions written back.

Function
REQ-007 States and encodings SHALL be SIDLE=0, SFETCH=1, SREAD=2, SCALC=3, SWRITE=4, SHALT=5; codes 6 and 7 SHALL go to SHALT.
REQ-008 SIDLE: imem_req=0; the FSM SHALL go to SFETCH on run=1; run is ignored in all other states.
REQ-009 SFETCH:
- imem_req=1 and imem_addr=pc, held stable until imem_ack.
- On imem_ack: latch imem_rdata into IR, pc<=pc+1 (wraps modulo 2^BUS_WIDTH), go to SREAD.
- imem_ack in the first SFETCH cycle is legal.
- imem_ack outside SFETCH is ignored.
REQ-010 rf_raddr1/2 SHALL equal IR src1/src2 in all states; alu_opcode, alu_addr1/2 and rf_waddr SHALL be driven from IR continuously.
REQ-011 SREAD:
- Latch rf_rdata1/2 into alu_value1/2.
- If IR opcode is all ones (halt), go to SHALT; otherwise go to SCALC.
REQ-012 SCALC:
- alu_en=1.
- alu_calc_done=1 with alu_err=0: go to SWRITE.
- alu_err=1: fault<=1, go to SHALT, no write.
- alu_calc_done=0: hold SCALC with alu_en=1.
REQ-013 SWRITE:
- rf_we=1 and rf_wdata=alu_result for exactly one cycle.
- retired SHALL increment, saturating at 16'hFFFF.
- Go to SFETCH.
REQ-014 SHALT SHALL assert halted=1 and hold until rst; all strobes are 0.
REQ-015 alu_en, imem_req and rf_we SHALL be zero outside SCALC, SFETCH and SWRITE respectively.
REQ-016 Best-case latency SHALL be 4 cycles per instruction (FETCH, READ, CALC, WRITE); each imem_ack wait cycle adds one.

Reset
REQ-017 rst SHALL asynchronously force state=SIDLE, pc=0, IR=0, alu_value1/2=0, retired=0, halted=0, fault=0 and all strobes to 0, including mid-operation; the first fetch after release is from address 0.

Structure
REQ-018 The state enum, state encodings, INSTR field offsets and the HALT opcode constant SHALL live in the shared params package beside DATA_WIDTH, BUS_WIDTH and OPCODE_WIDTH.
REQ-019 cpu_ctrl SHALL be a single module with no sub-modules; the ALU and register file stay external, and a top level instantiates all three.

Verification
REQ-020 ADD: rf[1]=5, rf[2]=7, instruction 0x00030102 with immediate ack -> rf_we exactly 4 cycles after run, waddr=3, wdata=12, retired=1.
REQ-021 Halt: instruction opcode 6'h3F -> SREAD then SHALT, halted=1, rf_we never asserted, pc=1.
REQ-022 Fetch stall: imem_ack delayed 3 cycles -> imem_req=1 with imem_addr constant for 4 cycles, then normal completion.
REQ-023 Wrap: pc preset via 255 fetched NOPs (XOR r0,r0) -> the fetch after address 255 requests address 0.
REQ-024 Fault: alu_err=1 in SCALC -> SHALT with fault=1, halted=1, no rf_we.
REQ-025 Reset in SCALC: rst pulsed -> state=0, all outputs zero immediately; after release and run, fetch from address 0.
